// File: rtl/mem_stage_hs.sv
// Multi-cycle MEM stage: handshake, wait-state counter, RMW store merge, load extract.
// Optional `MEM_MISALIGN_TRAP_EN: flag and suppress misaligned H/W accesses.
module mem_stage_hs #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] ALUResult,
    input  logic [31:0]       WDIn,
    input  logic [2:0]        Type,
    output logic              RespValid,
    output logic [31:0]       Data,
    output logic              MisalignErr,
    output logic              Stall
);
    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    function automatic size_t f_size(input logic [2:0] t);
        size_t s;
        unique case (t)
            3'b000, 3'b100: s = SZ_B;
            3'b001, 3'b101: s = SZ_H;
            default:        s = SZ_W;
        endcase
        return s;
    endfunction

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW+1:0] addr_q;
    logic [2:0]    type_q;
    logic [31:0]   wdata_q;
    logic          wr_q;
    logic [31:0]   data_q;
    logic          accept, access;
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [31:0]   rd_word, wmerge, ld_val;
    logic [7:0]    lb;
    logic [15:0]   lh;
    logic          unused_addr;

    assign unused_addr = ^ALUResult[ADDR_W-1:IW+2];

    assign accept    = (state_q == S_IDLE) && ReqValid && (MemRead || MemWrite);
    assign access    = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign ReqReady  = (state_q == S_IDLE);
    assign Stall     = (state_q != S_IDLE);
    assign RespValid = (state_q == S_RESP);
    assign Data      = data_q;

`ifdef MEM_MISALIGN_TRAP_EN
    logic  mis_d, mis_q, err_q;
    size_t in_sz;

    assign in_sz = f_size(Type);
    assign mis_d = ((in_sz == SZ_H) && ALUResult[0])
                 || ((in_sz == SZ_W) && (ALUResult[1:0] != 2'b00));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            mis_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (accept) mis_q <= mis_d;
            if (access) err_q <= mis_q;
        end
    end

    assign MisalignErr = err_q;
`else
    logic mis_q;

    // Legacy forced alignment: sub-lane address bits are simply ignored.
    assign mis_q       = 1'b0;
    assign MisalignErr = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_word = mem_q[addr_q[IW+1:2]];
        lb      = rd_word[{addr_q[1:0], 3'b000} +: 8];
        lh      = rd_word[{addr_q[1], 4'b0000} +: 16];
        wmerge  = rd_word;
        ld_val  = rd_word;
        unique case (f_size(type_q))
            SZ_B: begin
                wmerge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
                ld_val = {{24{lb[7] & ~type_q[2]}}, lb};
            end
            SZ_H: begin
                wmerge[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
                ld_val = {{16{lh[15] & ~type_q[2]}}, lh};
            end
            default: begin
                wmerge = wdata_q;
                ld_val = rd_word;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            type_q  <= 3'b000;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= ALUResult[IW+1:0];
                type_q  <= Type;
                wdata_q <= WDIn;
                wr_q    <= MemWrite;
            end
            if (access) data_q <= (wr_q || mis_q) ? 32'd0 : ld_val;
        end
    end

    // Array is deliberately not reset; an aborted request never reaches access.
    always_ff @(posedge CLK) begin
        if (access && wr_q && !mis_q) mem_q[addr_q[IW+1:2]] <= wmerge;
    end
endmodule

// File: tb/tb_mem_stage_hs.sv
// Randomized self-checking bench for mem_stage_hs against a byte-lane memory model.
// Model follows MEM_MISALIGN_TRAP_EN when that macro is defined.
module tb_mem_stage_hs;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int WS = 1;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        ReqValid = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] ALUResult = 32'd0;
    logic [31:0] WDIn = 32'd0;
    logic [2:0]  Type = 3'd0;
    logic        ReqReady, RespValid, MisalignErr, Stall;
    logic [31:0] Data;

    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] mm [DW];

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [2:0]  t;
    } op_t;

    mem_stage_hs #(.ADDR_W(AW), .DEPTH_WORDS(DW), .WAIT_STATES(WS)) dut (
        .CLK(CLK), .RSTn(RSTn), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .MemRead(MemRead), .MemWrite(MemWrite), .ALUResult(ALUResult),
        .WDIn(WDIn), .Type(Type), .RespValid(RespValid), .Data(Data),
        .MisalignErr(MisalignErr), .Stall(Stall)
    );

    always #5 CLK = ~CLK;

    function automatic int sz(input logic [2:0] t);
        if (t == 3'd0 || t == 3'd4) return 1;
        if (t == 3'd1 || t == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit mis(input logic [31:0] a, input logic [2:0] t);
`ifdef MEM_MISALIGN_TRAP_EN
        return (a % sz(t)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DW);
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] old, input logic [31:0] a,
                                            input logic [31:0] wd, input logic [2:0] t);
        int n = sz(t);
        int off = int'(a % 4) / n * n;
        logic [31:0] mask;
        if (n == 4) return wd;
        mask = ((n == 1) ? 32'hFF : 32'hFFFF) << (8 * off);
        return (old & ~mask) | ((wd << (8 * off)) & mask);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] t);
        int n = sz(t);
        int off = int'(a % 4) / n * n;
        logic [31:0] v = w >> (8 * off);
        if (n == 4) return w;
        if (n == 1) begin
            v = v & 32'hFF;
            if (t < 3'd4 && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else begin
            v = v & 32'hFFFF;
            if (t < 3'd4 && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic void model(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [2:0] t, output logic [31:0] d, output bit e);
        e = mis(a, t);
        d = 32'd0;
        if (wr) begin
            if (!e) mm[widx(a)] = m_store(mm[widx(a)], a, wd, t);
        end else if (!e) begin
            d = m_load(mm[widx(a)], a, t);
        end
    endfunction

    task automatic txn(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] t, output int acc_wait, output int lat,
                       output int stalls, output logic [31:0] d, output bit e);
        ReqValid = 1'b1; MemWrite = wr; MemRead = rd;
        ALUResult = a; WDIn = wd; Type = t;
        acc_wait = 0;
        while (!ReqReady && acc_wait < 40) begin
            @(posedge CLK); #1;
            acc_wait++;
        end
        @(posedge CLK); #1;
        ReqValid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        lat = 0; stalls = 0;
        while (lat < 40) begin
            if (Stall) stalls++;
            if (RespValid) break;
            @(posedge CLK); #1;
            lat++;
        end
        if (!RespValid) lat = -1;
        d = Data;
        e = MisalignErr;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (ReqReady !== 1'b1 || Stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_in: ReqReady=%b Stall=%b need 1/0", ReqReady, Stall);
        end
        @(negedge CLK); RSTn = 1'b1;
        @(posedge CLK); #1;
        n_tests++;
        if (ReqReady !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b need 1", ReqReady); end
        n_tests++;
        if (RespValid !== 1'b0) begin n_fail++; $display("FAIL rst_resp: got %b need 0", RespValid); end
        n_tests++;
        if (Data !== 32'd0) begin n_fail++; $display("FAIL rst_data: got %h need 0", Data); end
        n_tests++;
        if (MisalignErr !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b need 0", MisalignErr); end
        n_tests++;
        if (Stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b need 0", Stall); end
    endtask

    task automatic test_latency();
        int aw, lat, st; logic [31:0] d, ed; bit e, ee;
        txn(1, 0, 32'h10, 32'hDEAD_BEEF, 3'd2, aw, lat, st, d, e);
        model(1, 32'h10, 32'hDEAD_BEEF, 3'd2, ed, ee);
        n_tests++;
        if (lat != WS + 1) begin n_fail++; $display("FAIL sw_latency: got %0d need %0d", lat, WS + 1); end
        n_tests++;
        if (st != WS + 2) begin n_fail++; $display("FAIL sw_stall_cycles: got %0d need %0d", st, WS + 2); end
        n_tests++;
        if (d !== ed || e !== ee) begin n_fail++; $display("FAIL sw_data: got %h/%b need %h/%b", d, e, ed, ee); end
        @(posedge CLK); #1;
        n_tests++;
        if (RespValid !== 1'b0 || ReqReady !== 1'b1 || Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_strobe: RespValid=%b ReqReady=%b Stall=%b need 0/1/0", RespValid, ReqReady, Stall);
        end
    endtask

    task automatic test_byte_half();
        op_t ops[$];
        int aw, lat, st; logic [31:0] d, ed; bit e, ee;
        ops.push_back('{1, 32'h11, 32'h7F, 3'd0});
        ops.push_back('{0, 32'h10, 32'h0, 3'd2});
        ops.push_back('{0, 32'h13, 32'h0, 3'd0});
        ops.push_back('{0, 32'h13, 32'h0, 3'd4});
        ops.push_back('{1, 32'h20, $urandom, 3'd2});
        ops.push_back('{1, 32'h22, 32'h8001, 3'd1});
        ops.push_back('{0, 32'h22, 32'h0, 3'd1});
        ops.push_back('{0, 32'h22, 32'h0, 3'd5});
        ops.push_back('{0, 32'h22 + 4 * DW, 32'h0, 3'd1});
        ops.push_back('{0, 32'h20, 32'h0, 3'd2});
        foreach (ops[i]) begin
            txn(ops[i].wr, !ops[i].wr, ops[i].a, ops[i].wd, ops[i].t, aw, lat, st, d, e);
            model(ops[i].wr, ops[i].a, ops[i].wd, ops[i].t, ed, ee);
            n_tests++;
            if (lat != WS + 1 || d !== ed || e !== ee) begin
                n_fail++;
                $display("FAIL bh_op%0d: lat=%0d data=%h err=%b need lat=%0d data=%h err=%b",
                         i, lat, d, e, WS + 1, ed, ee);
            end
        end
    endtask

    task automatic test_misalign();
        op_t ops[$];
        int aw, lat, st; logic [31:0] d, ed; bit e, ee;
        ops.push_back('{1, 32'h30, $urandom, 3'd2});
        ops.push_back('{1, 32'h31, 32'h1234_5678, 3'd2});
        ops.push_back('{0, 32'h30, 32'h0, 3'd2});
        ops.push_back('{1, 32'h34, $urandom, 3'd2});
        ops.push_back('{1, 32'h35, 32'hA5A5, 3'd1});
        ops.push_back('{0, 32'h35, 32'h0, 3'd5});
        ops.push_back('{0, 32'h36, 32'h0, 3'd7});
        ops.push_back('{0, 32'h34, 32'h0, 3'd2});
        foreach (ops[i]) begin
            txn(ops[i].wr, 1'b1, ops[i].a, ops[i].wd, ops[i].t, aw, lat, st, d, e);
            model(ops[i].wr, ops[i].a, ops[i].wd, ops[i].t, ed, ee);
            n_tests++;
            if (lat != WS + 1 || d !== ed || e !== ee) begin
                n_fail++;
                $display("FAIL mis_op%0d: lat=%0d data=%h err=%b need lat=%0d data=%h err=%b",
                         i, lat, d, e, WS + 1, ed, ee);
            end
        end
    endtask

    task automatic test_hold_and_resp_req();
        int aw, lat, st; logic [31:0] d, ed, d2, ed2; bit e, ee, e2, ee2;
        txn(0, 1, 32'h13, 32'h0, 3'd0, aw, lat, st, d, e);
        model(0, 32'h13, 32'h0, 3'd0, ed, ee);
        n_tests++;
        if (d !== ed) begin n_fail++; $display("FAIL hold_ld: got %h need %h", d, ed); end
        repeat (3) begin @(posedge CLK); #1; end
        n_tests++;
        if (Data !== ed || MisalignErr !== ee) begin
            n_fail++; $display("FAIL data_hold: got %h/%b need %h/%b", Data, MisalignErr, ed, ee);
        end
        txn(0, 1, 32'h10, 32'h0, 3'd2, aw, lat, st, d, e);
        model(0, 32'h10, 32'h0, 3'd2, ed, ee);
        txn(0, 1, 32'h22, 32'h0, 3'd5, aw, lat, st, d2, e2);
        model(0, 32'h22, 32'h0, 3'd5, ed2, ee2);
        n_tests++;
        if (aw != 1) begin n_fail++; $display("FAIL resp_req_wait: got %0d need 1", aw); end
        n_tests++;
        if (d2 !== ed2 || lat != WS + 1) begin
            n_fail++; $display("FAIL resp_req_data: got %h lat %0d need %h lat %0d", d2, lat, ed2, WS + 1);
        end
    endtask

    task automatic test_noop();
        int bad = 0;
        ReqValid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        ALUResult = 32'h10; Type = 3'd2;
        repeat (6) begin
            @(posedge CLK); #1;
            if (Stall !== 1'b0 || RespValid !== 1'b0 || ReqReady !== 1'b1) bad++;
        end
        ReqValid = 1'b0;
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL noop: got %0d busy cycles need 0", bad); end
    endtask

    task automatic test_reset_mid();
        int aw, lat, st, seen; logic [31:0] d, ed, v; bit e, ee;
        txn(1, 0, 32'h40, 32'h1111_2222, 3'd2, aw, lat, st, d, e);
        model(1, 32'h40, 32'h1111_2222, 3'd2, ed, ee);
        v = $urandom;
        ReqValid = 1'b1; MemWrite = 1'b1; ALUResult = 32'h40; WDIn = v; Type = 3'd2;
        while (!ReqReady) begin @(posedge CLK); #1; end
        @(posedge CLK); #1;
        ReqValid = 1'b0; MemWrite = 1'b0;
        #2 RSTn = 1'b0;
        #1;
        n_tests++;
        if (Stall !== 1'b0 || ReqReady !== 1'b1) begin
            n_fail++; $display("FAIL mid_rst_idle: Stall=%b ReqReady=%b need 0/1", Stall, ReqReady);
        end
        #2 RSTn = 1'b1;
        seen = 0;
        repeat (5) begin @(posedge CLK); #1; if (RespValid) seen++; end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL mid_rst_resp: got %0d strobes need 0", seen); end
        txn(0, 1, 32'h40, 32'h0, 3'd2, aw, lat, st, d, e);
        model(0, 32'h40, 32'h0, 3'd2, ed, ee);
        n_tests++;
        if (d !== ed) begin n_fail++; $display("FAIL mid_rst_discard: got %h need %h", d, ed); end
        txn(1, 0, 32'h40, v, 3'd2, aw, lat, st, d, e);
        model(1, 32'h40, v, 3'd2, ed, ee);
        #2 RSTn = 1'b0;
        #2 RSTn = 1'b1;
        txn(0, 1, 32'h40, 32'h0, 3'd2, aw, lat, st, d, e);
        model(0, 32'h40, 32'h0, 3'd2, ed, ee);
        n_tests++;
        if (d !== ed) begin n_fail++; $display("FAIL post_access_rst: got %h need %h", d, ed); end
    endtask

    task automatic test_random();
        int aw, lat, st; logic [31:0] d, ed, a, wd; bit e, ee, wr, rd; logic [2:0] t;
        for (int i = 0; i < DW; i++) begin
            wd = $urandom;
            a = 32'(i * 4) + (32'($urandom_range(0, 7)) << 12);
            txn(1, 0, a, wd, 3'd2, aw, lat, st, d, e);
            model(1, a, wd, 3'd2, ed, ee);
            n_tests++;
            if (lat != WS + 1 || d !== ed) begin
                n_fail++; $display("FAIL init%0d: lat=%0d data=%h need %0d/%h", i, lat, d, WS + 1, ed);
            end
        end
        for (int i = 0; i < 150; i++) begin
            wr = 1'($urandom);
            rd = wr ? 1'($urandom) : 1'b1;
            a = $urandom;
            wd = $urandom;
            t = 3'($urandom);
            txn(wr, rd, a, wd, t, aw, lat, st, d, e);
            model(wr, a, wd, t, ed, ee);
            n_tests++;
            if (lat != WS + 1 || st != WS + 2 || d !== ed || e !== ee) begin
                n_fail++;
                $display("FAIL rnd%0d wr=%b a=%h t=%0d: lat=%0d st=%0d data=%h err=%b need %0d/%0d/%h/%b",
                         i, wr, a, t, lat, st, d, e, WS + 1, WS + 2, ed, ee);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_byte_half();
        test_misalign();
        test_hold_and_resp_req();
        test_noop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
